// File: rtl/tour_cmd_sequencer_pkg.sv
// tour_pkg: shared constants and types for the tour command sequencer.
//   - opcode and heading fields of the 16-bit movement command
//   - response bytes returned to the host
//   - sequencer state enum
//   - bit positions of the one-hot knight move encoding
// Optional feature macro used elsewhere in this slice: TOUR_UART_ABORT_EN.
package tour_pkg;

   // cmd[15:12] opcodes
   localparam logic [3:0] OP_MOVE         = 4'b0100;
   localparam logic [3:0] OP_MOVE_FANFARE = 4'b0101;

   // cmd[11:4] headings
   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   // host response bytes
   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_DONE = 8'h5A;

   typedef enum logic [2:0] {
      IDLE,
      VERT,
      VERT_WAIT,
      HORZ,
      HORZ_WAIT
   } state_t;

   // Bit positions of the one-hot move, listed with (dx,dy)
   localparam int MV_B0 = 0;   // (+1,+2)
   localparam int MV_B1 = 1;   // (-1,+2)
   localparam int MV_B2 = 2;   // (-2,+1)
   localparam int MV_B3 = 3;   // (-2,-1)
   localparam int MV_B4 = 4;   // (-1,-2)
   localparam int MV_B5 = 5;   // (+1,-2)
   localparam int MV_B6 = 6;   // (+2,-1)
   localparam int MV_B7 = 7;   // (+2,+1)

   function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [3:0] squares);
      return {op, hdg, squares};
   endfunction

endpackage

// File: rtl/tour_cmd_sequencer_if.sv
// tour_cmd_sequencer_if: command/response handshake bundle around the
// sequencer.
//   UART side     : cmd_UART, cmd_rdy_UART, clr_cmd_rdy_UART
//   cmd proc side : cmd, cmd_rdy, clr_cmd_rdy, send_resp
//   host response : resp
// modport master is the sequencer's view, modport slave is the
// surrounding UART wrapper / command processor view.
interface tour_cmd_sequencer_if;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   modport master (
      input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
   );

   modport slave (
      output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
   );
endinterface

// File: rtl/tour_cmd_sequencer_knight_move_decode.sv
// knight_move_decode: combinational decode of a one-hot knight move.
//   move     in  8   one-hot move
//   dx, dy   out 3   signed displacement (0,0 for zero / non-one-hot)
//   vert_cmd out 16  {MOVE, N|S, |dy|}
//   horz_cmd out 16  {MOVE_FANFARE, E|W, |dx|}
module knight_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]        move,
   output logic signed [2:0] dx,
   output logic signed [2:0] dy,
   output logic [15:0]       vert_cmd,
   output logic [15:0]       horz_cmd
);

   logic [2:0] dx_abs;
   logic [2:0] dy_abs;

   always_comb begin
      dx = 3'sd0;
      dy = 3'sd0;
      case (move)
         8'd1 << MV_B0: begin dx =  3'sd1; dy =  3'sd2; end
         8'd1 << MV_B1: begin dx = -3'sd1; dy =  3'sd2; end
         8'd1 << MV_B2: begin dx = -3'sd2; dy =  3'sd1; end
         8'd1 << MV_B3: begin dx = -3'sd2; dy = -3'sd1; end
         8'd1 << MV_B4: begin dx = -3'sd1; dy = -3'sd2; end
         8'd1 << MV_B5: begin dx =  3'sd1; dy = -3'sd2; end
         8'd1 << MV_B6: begin dx =  3'sd2; dy = -3'sd1; end
         8'd1 << MV_B7: begin dx =  3'sd2; dy =  3'sd1; end
         default:       begin dx =  3'sd0; dy =  3'sd0; end
      endcase
   end

   // Magnitudes never exceed 2, so a 3-bit two's-complement negate is safe.
   assign dx_abs = dx[2] ? (~dx + 3'd1) : dx;
   assign dy_abs = dy[2] ? (~dy + 3'd1) : dy;

   // A zero displacement falls on the N / E side of each compare, which is
   // the heading an invalid move should carry.
   assign vert_cmd = make_cmd(OP_MOVE, dy[2] ? HDG_S : HDG_N, {1'b0, dy_abs});
   assign horz_cmd = make_cmd(OP_MOVE_FANFARE, dx[2] ? HDG_W : HDG_E, {1'b0, dx_abs});

endmodule

// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer: between the tour solver and the command processor.
// In IDLE host UART commands pass straight through; after start_tour the
// stored tour is replayed as a vertical leg then a horizontal (fanfare) leg
// per knight move.
//   clk, rst_n  clock, asynchronous active-low reset
//   start_tour  in   one-cycle pulse, begin replay
//   move        in   one-hot move read combinationally at mv_indx
//   mv_indx     out  index of the move being replayed
//   bus         master modport: UART/cmd-proc handshakes and resp byte
// Optional: TOUR_UART_ABORT_EN lets a UART command arriving mid-tour abort
// the replay at the next send_resp.
module tour_cmd_sequencer
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_tour,
   input  logic [7:0]           move,
   output logic [4:0]           mv_indx,
   tour_cmd_sequencer_if.master bus
);

   state_t     state_reg;
   logic [4:0] mv_indx_reg;
   logic [15:0] vert_cmd;
   logic [15:0] horz_cmd;
   logic       last_move;
   logic       abort_hit;
   logic       tour_end;

   knight_move_decode u_decode (
      .move     (move),
      .dx       (),
      .dy       (),
      .vert_cmd (vert_cmd),
      .horz_cmd (horz_cmd)
   );

   assign last_move = (mv_indx_reg == 5'(NUM_MOVES - 1));

`ifdef TOUR_UART_ABORT_EN
   logic abort_reg;
   // A UART request seen on the same cycle as send_resp also aborts.
   assign abort_hit = abort_reg | bus.cmd_rdy_UART;
`else
   assign abort_hit = 1'b0;
`endif

   // Wait-state send_resp that returns to IDLE this cycle.
   assign tour_end = bus.send_resp &&
                     (((state_reg == VERT_WAIT) && abort_hit) ||
                      ((state_reg == HORZ_WAIT) && (last_move || abort_hit)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         mv_indx_reg <= 5'd0;
`ifdef TOUR_UART_ABORT_EN
         abort_reg   <= 1'b0;
`endif
      end else begin
`ifdef TOUR_UART_ABORT_EN
         if (state_reg != IDLE && bus.cmd_rdy_UART)
            abort_reg <= 1'b1;
         if (state_reg == IDLE || tour_end)
            abort_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (start_tour) begin
                  state_reg   <= VERT;
                  mv_indx_reg <= 5'd0;
               end
            end
            VERT: begin
               if (bus.clr_cmd_rdy)
                  state_reg <= VERT_WAIT;
            end
            VERT_WAIT: begin
               if (bus.send_resp) begin
                  if (tour_end) begin
                     state_reg   <= IDLE;
                     mv_indx_reg <= 5'd0;
                  end else begin
                     state_reg <= HORZ;
                  end
               end
            end
            HORZ: begin
               if (bus.clr_cmd_rdy)
                  state_reg <= HORZ_WAIT;
            end
            HORZ_WAIT: begin
               if (bus.send_resp) begin
                  if (tour_end) begin
                     state_reg   <= IDLE;
                     mv_indx_reg <= 5'd0;
                  end else begin
                     state_reg   <= VERT;
                     mv_indx_reg <= mv_indx_reg + 5'd1;
                  end
               end
            end
            default: begin
               state_reg   <= IDLE;
               mv_indx_reg <= 5'd0;
            end
         endcase
      end
   end

   assign mv_indx = mv_indx_reg;

   always_comb begin
      bus.cmd              = bus.cmd_UART;
      bus.cmd_rdy          = bus.cmd_rdy_UART;
      bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
      case (state_reg)
         IDLE: begin
            // start_tour takes priority; leave the UART command pending.
            if (start_tour) begin
               bus.cmd_rdy          = 1'b0;
               bus.clr_cmd_rdy_UART = 1'b0;
            end
         end
         VERT: begin
            bus.cmd              = vert_cmd;
            bus.cmd_rdy          = 1'b1;
            bus.clr_cmd_rdy_UART = 1'b0;
         end
         VERT_WAIT: begin
            bus.cmd              = vert_cmd;
            bus.cmd_rdy          = 1'b0;
            bus.clr_cmd_rdy_UART = 1'b0;
         end
         HORZ: begin
            bus.cmd              = horz_cmd;
            bus.cmd_rdy          = 1'b1;
            bus.clr_cmd_rdy_UART = 1'b0;
         end
         HORZ_WAIT: begin
            bus.cmd              = horz_cmd;
            bus.cmd_rdy          = 1'b0;
            bus.clr_cmd_rdy_UART = 1'b0;
         end
         default: begin
            bus.cmd_rdy          = 1'b0;
            bus.clr_cmd_rdy_UART = 1'b0;
         end
      endcase
   end

   // DONE in IDLE and on the send_resp that takes us back there.
   assign bus.resp = ((state_reg == IDLE) || tour_end) ? RESP_DONE : RESP_ACK;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb_tour_cmd_sequencer: directed table-driven bench for tour_cmd_sequencer.
// The solver is modelled by a move table indexed by mv_indx; the command
// processor is driven by hand-written clr_cmd_rdy / send_resp pulses.
module tb_tour_cmd_sequencer;
   import tour_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_tour = 1'b0;
   logic [7:0] move;
   logic [4:0] mv_indx;

   tour_cmd_sequencer_if bus();

   tour_cmd_sequencer #(.NUM_MOVES(24)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_tour (start_tour),
      .move       (move),
      .mv_indx    (mv_indx),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  mv;
      logic [15:0] vert;
      logic [15:0] horz;
   } vec_t;

   vec_t       vecs [10];
   logic [7:0] tour_mv [32];

   assign move = tour_mv[mv_indx];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full vertical+horizontal pair for move i. Optionally pokes start_tour
   // while waiting, which must be ignored.
   task automatic leg_pair(input int i, input bit poke_start);
      chk("mv_indx", {11'd0, mv_indx}, 16'(i));
      chk("vert_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
      chk("vert_cmd", bus.cmd, vecs[i % 10].vert);
      chk("resp_vert", {8'd0, bus.resp}, {8'd0, RESP_ACK});
      bus.clr_cmd_rdy = 1'b1;
      #1 chk("clr_uart_gated", {15'd0, bus.clr_cmd_rdy_UART}, 16'd0);
      step();
      bus.clr_cmd_rdy = 1'b0;
      #1 chk("vwait_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      if (poke_start) begin
         start_tour = 1'b1;
         step();
         start_tour = 1'b0;
         #1 chk("start_ignored_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
         chk("start_ignored_idx", {11'd0, mv_indx}, 16'(i));
      end
      bus.send_resp = 1'b1;
      #1 chk("resp_vwait", {8'd0, bus.resp}, {8'd0, RESP_ACK});
      step();
      bus.send_resp = 1'b0;
      #1 chk("horz_cmd", bus.cmd, vecs[i % 10].horz);
      chk("horz_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
      bus.clr_cmd_rdy = 1'b1;
      step();
      bus.clr_cmd_rdy = 1'b0;
      #1 chk("hwait_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      bus.send_resp = 1'b1;
      #1 chk("resp_hwait", {8'd0, bus.resp}, {8'd0, (i == 23) ? RESP_DONE : RESP_ACK});
      step();
      bus.send_resp = 1'b0;
      #1;
   endtask

   task automatic start_pulse();
      start_tour = 1'b1;
      step();
      start_tour = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // move, expected vertical leg, expected horizontal leg
      vecs[0] = '{8'h01, 16'h4002, 16'h5BF1};
      vecs[1] = '{8'h02, 16'h4002, 16'h53F1};
      vecs[2] = '{8'h04, 16'h4001, 16'h53F2};
      vecs[3] = '{8'h08, 16'h47F1, 16'h53F2};
      vecs[4] = '{8'h10, 16'h47F2, 16'h53F1};
      vecs[5] = '{8'h20, 16'h47F2, 16'h5BF1};
      vecs[6] = '{8'h40, 16'h47F1, 16'h5BF2};
      vecs[7] = '{8'h80, 16'h4001, 16'h5BF2};
      vecs[8] = '{8'h00, 16'h4000, 16'h5BF0};
      vecs[9] = '{8'h03, 16'h4000, 16'h5BF0};
      for (int i = 0; i < 32; i++) tour_mv[i] = vecs[i % 10].mv;

      bus.cmd_UART     = 16'hBEEF;
      bus.cmd_rdy_UART = 1'b0;
      bus.clr_cmd_rdy  = 1'b0;
      bus.send_resp    = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_mv_indx", {11'd0, mv_indx}, 16'd0);
      chk("rst_resp", {8'd0, bus.resp}, {8'd0, RESP_DONE});
      chk("rst_cmd", bus.cmd, 16'hBEEF);
      chk("rst_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      step();
      rst_n = 1'b1;
      step();

      // IDLE passthrough
      bus.cmd_UART = 16'h2000;
      bus.cmd_rdy_UART = 1'b1;
      #1 chk("pass_cmd", bus.cmd, 16'h2000);
      chk("pass_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
      chk("pass_resp", {8'd0, bus.resp}, {8'd0, RESP_DONE});
      bus.clr_cmd_rdy = 1'b1;
      #1 chk("pass_clr", {15'd0, bus.clr_cmd_rdy_UART}, 16'd1);
      step();
      bus.clr_cmd_rdy = 1'b0;

      // start_tour beats a simultaneous UART command
      start_tour = 1'b1;
      #1 chk("start_wins_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      step();
      start_tour = 1'b0;
      #1 chk("start_wins_cmd", bus.cmd, 16'h4002);
      chk("start_wins_rdy2", {15'd0, bus.cmd_rdy}, 16'd1);
      bus.cmd_rdy_UART = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Full 24-move tour, start_tour poked mid-tour
      start_pulse();
      for (int i = 0; i < 24; i++) leg_pair(i, i == 5);
      bus.cmd_UART = 16'h3003;
      #1 chk("end_mv_indx", {11'd0, mv_indx}, 16'd0);
      chk("end_resp", {8'd0, bus.resp}, {8'd0, RESP_DONE});
      chk("end_cmd", bus.cmd, 16'h3003);
      chk("end_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      step();

      // Asynchronous reset in HORZ_WAIT at move 7
      start_pulse();
      for (int i = 0; i < 7; i++) leg_pair(i, 1'b0);
      bus.clr_cmd_rdy = 1'b1; step(); bus.clr_cmd_rdy = 1'b0;
      bus.send_resp = 1'b1;   step(); bus.send_resp = 1'b0;
      bus.clr_cmd_rdy = 1'b1; step(); bus.clr_cmd_rdy = 1'b0;
      #1 chk("hw7_idx", {11'd0, mv_indx}, 16'd7);
      chk("hw7_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      bus.cmd_UART = 16'h1234;
      #2 rst_n = 1'b0;
      #1 chk("arst_idx", {11'd0, mv_indx}, 16'd0);
      chk("arst_cmd", bus.cmd, 16'h1234);
      chk("arst_resp", {8'd0, bus.resp}, {8'd0, RESP_DONE});
      step();
      rst_n = 1'b1;
      step();

      // UART command arriving in VERT_WAIT at move 3
      start_pulse();
      for (int i = 0; i < 3; i++) leg_pair(i, 1'b0);
      chk("ab_vert_cmd", bus.cmd, vecs[3].vert);
      bus.clr_cmd_rdy = 1'b1; step(); bus.clr_cmd_rdy = 1'b0;
      bus.cmd_UART = 16'h2000;
      bus.cmd_rdy_UART = 1'b1;
      bus.clr_cmd_rdy = 1'b1;
      #1 chk("ab_rdy_held", {15'd0, bus.cmd_rdy}, 16'd0);
      chk("ab_clr_gated", {15'd0, bus.clr_cmd_rdy_UART}, 16'd0);
      bus.clr_cmd_rdy = 1'b0;
      step();
      bus.send_resp = 1'b1;
`ifdef TOUR_UART_ABORT_EN
      #1 chk("ab_resp", {8'd0, bus.resp}, {8'd0, RESP_DONE});
      step();
      bus.send_resp = 1'b0;
      #1 chk("ab_idx", {11'd0, mv_indx}, 16'd0);
      chk("ab_fwd_cmd", bus.cmd, 16'h2000);
      chk("ab_fwd_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
`else
      #1 chk("noab_resp", {8'd0, bus.resp}, {8'd0, RESP_ACK});
      step();
      bus.send_resp = 1'b0;
      #1 chk("noab_horz", bus.cmd, vecs[3].horz);
      chk("noab_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
      bus.clr_cmd_rdy = 1'b1; step(); bus.clr_cmd_rdy = 1'b0;
      bus.send_resp = 1'b1;   step(); bus.send_resp = 1'b0;
      #1 chk("noab_idx", {11'd0, mv_indx}, 16'd4);
      chk("noab_vert", bus.cmd, vecs[4].vert);
`endif
      bus.cmd_rdy_UART = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
